// File: rtl/ddfs_pkg.sv
// Shared types and default parameters for the DDFS frequency meter and the DDFS core.
package ddfs_pkg;

  localparam int ACC_WIDTH_DEF = 23;
  localparam int NCYC_LOG2_DEF = 4;
  localparam int CNT_WIDTH_DEF = 20;
  localparam int HYST_DEF      = 8;

  typedef enum logic {
    ST_IDLE,
    ST_COUNT
  } meter_state_t;

endpackage

// File: rtl/udiv_restoring.sv
// Unsigned restoring divider: one quotient bit per cycle, saturating when the
// quotient does not fit in QUOT_W bits.
module udiv_restoring
  import ddfs_pkg::*;
#(
  parameter int DIVIDEND_W = 28,
  parameter int DIVISOR_W  = 20,
  parameter int QUOT_W     = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [QUOT_W-1:0]     quotient,
  output logic                  busy,
  output logic                  done
);

  localparam int IW = $clog2(QUOT_W + 1);

  logic [DIVISOR_W-1:0] rem;
  logic [DIVISOR_W-1:0] dsr;
  logic [QUOT_W-1:0]    lo;
  logic [IW-1:0]        iter;
  logic                 sat;
  logic [DIVISOR_W-1:0] hi_ext;
  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W:0]   diff;
  logic                 q_bit;

  // The bits above the quotient field form the initial partial remainder; if
  // that already reaches the divisor, the quotient overflows QUOT_W bits.
  assign hi_ext = DIVISOR_W'(dividend[DIVIDEND_W-1:QUOT_W]);

  // NOTE: every combinational output gets a default before any condition,
  // so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    trial = {rem, lo[QUOT_W-1]};
    diff  = '0;
    q_bit = 1'b0;
    if (trial >= {1'b0, dsr}) begin
      diff  = trial - {1'b0, dsr};
      q_bit = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem  <= '0;
      dsr  <= '0;
      lo   <= '0;
      iter <= '0;
      sat  <= 1'b0;
      busy <= 1'b0;
    end else if (start) begin
      rem  <= hi_ext;
      dsr  <= divisor;
      lo   <= dividend[QUOT_W-1:0];
      iter <= '0;
      sat  <= (hi_ext >= divisor);
      busy <= 1'b1;
    end else if (busy) begin
      if (iter == IW'(QUOT_W)) begin
        busy <= 1'b0;
      end else begin
        if (q_bit) rem <= diff[DIVISOR_W-1:0];
        else       rem <= trial[DIVISOR_W-1:0];
        lo   <= {lo[QUOT_W-2:0], q_bit};
        iter <= iter + 1'b1;
      end
    end
  end

  assign done     = busy && (iter == IW'(QUOT_W));
  assign quotient = sat ? '1 : lo;

endmodule

// File: rtl/ddfs_freq_meter.sv
// Measures the period of a signed sample stream over NCYC cycles and converts
// it to the equivalent DDFS tuning word.
module ddfs_freq_meter
  import ddfs_pkg::*;
#(
  parameter int ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int NCYC_LOG2 = NCYC_LOG2_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF,
  parameter int HYST      = HYST_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           samp,
  input  logic                 samp_valid,
  output logic [ACC_WIDTH-1:0] fcontrol_est,
  output logic                 est_valid,
  output logic                 locked,
  output logic                 busy
);

  localparam int DVD_W = ACC_WIDTH + NCYC_LOG2 + 1;
  localparam logic [DVD_W-1:0] DIVIDEND = DVD_W'(1) << (ACC_WIDTH + NCYC_LOG2);
  localparam logic signed [7:0] HYST_POS = 8'(HYST);
  localparam logic signed [7:0] HYST_NEG = -HYST_POS;

  meter_state_t         state, state_nx;
  logic [CNT_WIDTH-1:0] cnt, cnt_nx, cnt_inc;
  logic [NCYC_LOG2-1:0] edges, edges_nx;
  logic                 s_high;
  logic                 rise;
  logic                 timeout;
  logic                 div_start;
  logic                 div_done;
  logic [ACC_WIDTH-1:0] div_q;
  logic signed [7:0]    samp_s;

  assign samp_s  = samp;
  assign rise    = samp_valid && !s_high && (samp_s >= HYST_POS);
  // Saturate so an edge on the last count cannot wrap into a short window.
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    edges_nx  = edges;
    div_start = 1'b0;
    timeout   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rise) begin
          cnt_nx   = CNT_WIDTH'(1);
          edges_nx = '0;
          state_nx = ST_COUNT;
        end
      end
      ST_COUNT: begin
        if (samp_valid) begin
          if (rise && edges == '1) begin
            div_start = 1'b1;
            cnt_nx    = CNT_WIDTH'(1);
            edges_nx  = '0;
          end else if (rise) begin
            edges_nx = edges + 1'b1;
            cnt_nx   = cnt_inc;
          end else if (cnt == '1) begin
            timeout  = 1'b1;
            state_nx = ST_IDLE;
          end else begin
            cnt_nx = cnt_inc;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      edges  <= '0;
      s_high <= 1'b1;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      edges <= edges_nx;
      if (samp_valid) begin
        if (samp_s <= HYST_NEG)      s_high <= 1'b0;
        else if (samp_s >= HYST_POS) s_high <= 1'b1;
      end
    end
  end

  udiv_restoring #(
    .DIVIDEND_W(DVD_W),
    .DIVISOR_W (CNT_WIDTH),
    .QUOT_W    (ACC_WIDTH)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (DIVIDEND),
    .divisor  (cnt),
    .quotient (div_q),
    .busy     (busy),
    .done     (div_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcontrol_est <= '0;
      est_valid    <= 1'b0;
      locked       <= 1'b0;
    end else begin
      est_valid <= div_done;
      if (div_done) begin
        fcontrol_est <= div_q;
        locked       <= 1'b1;
      end else if (timeout) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ddfs_freq_meter.sv
// Self-checking bench for ddfs_freq_meter: spec-level stimulus model feeding a
// scoreboard of expected estimates and their due edges.
module tb_ddfs_freq_meter;
  import ddfs_pkg::*;

  localparam int  CW   = 12;
  localparam int  ACC  = ACC_WIDTH_DEF;
  localparam int  H    = HYST_DEF;
  localparam int  NCYC = 1 << NCYC_LOG2_DEF;
  localparam int  LAT  = ACC + 1;
  localparam int  MAXC = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [7:0]     samp;
  logic           samp_valid;
  logic [ACC-1:0] fcontrol_est;
  logic           est_valid, locked, busy;

  ddfs_freq_meter #(.CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst          (rst),
    .samp         (samp),
    .samp_valid   (samp_valid),
    .fcontrol_est (fcontrol_est),
    .est_valid    (est_valid),
    .locked       (locked),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint q;
    int     tol;
    longint due;
  } exp_t;

  typedef struct {
    int     period;
    int     every;
    int     windows;
    longint exp_q;
  } vec_t;

  exp_t   sb[$];
  vec_t   vecs[3];
  int     checks = 0, failures = 0;
  longint edge_n = 0;
  int     n_pushed = 0, n_seen = 0;

  // Spec-level model of the Schmitt detector and window counting
  bit     m_high, m_count, m_timed_out;
  int     m_cnt, m_edges;
  longint cur_q;
  int     cur_tol;

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input longint act, input longint exp, input int tol);
    longint d;
    checks++;
    d = (act > exp) ? act - exp : exp - act;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d +/- %0d", name, act, exp, tol);
    end
  endtask

  always @(negedge clk) begin
    if (est_valid) begin
      n_seen++;
      if (sb.size() == 0) begin
        check("unexpected_est_valid", 64'(est_valid), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("est_latency_edge", 64'(edge_n), 64'(e.due));
        check_tol("fcontrol_est", longint'(fcontrol_est), e.q, e.tol);
      end
    end
  end

  task automatic model_reset();
    m_high = 1'b1;
    m_count = 1'b0;
    m_cnt = 0;
    m_edges = 0;
    m_timed_out = 1'b0;
  endtask

  task automatic model_step(input logic [7:0] s, input logic v);
    int  si;
    bit  rise;
    longint t;
    if (!v) return;
    si = int'($signed(s));
    t = edge_n + 1;
    rise = !m_high && (si >= H);
    if (si <= -H) m_high = 1'b0;
    else if (si >= H) m_high = 1'b1;
    if (!m_count) begin
      if (rise) begin
        m_count = 1'b1;
        m_cnt = 1;
        m_edges = 0;
      end
    end else if (rise && m_edges == NCYC - 1) begin
      sb.push_back('{q: cur_q, tol: cur_tol, due: t + LAT});
      n_pushed++;
      m_cnt = 1;
      m_edges = 0;
    end else if (rise) begin
      m_edges++;
      if (m_cnt < MAXC) m_cnt++;
    end else if (m_cnt == MAXC) begin
      m_count = 1'b0;
      m_timed_out = 1'b1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic step(input logic [7:0] s, input logic v);
    samp = s;
    samp_valid = v;
    model_step(s, v);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    samp_valid = 1'b0;
    sb.delete();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  function automatic logic [7:0] sine_s(input real x);
    int v;
    v = $rtoi($floor(100.0 * $sin(6.283185307179586 * x) + 0.5));
    return 8'(v);
  endfunction

  // Drive a sine of the given period until `windows` estimates are scheduled.
  task automatic run_sine(input int period, input int every, input int windows,
                          input longint q, input int tol);
    int target, k, limit, n;
    logic [7:0] s;
    cur_q = q;
    cur_tol = tol;
    target = n_pushed + windows;
    limit = (windows + 2) * NCYC * period * every;
    k = 0;
    n = 0;
    while (n_pushed < target && n < limit) begin
      s = sine_s(real'(k) / real'(period));
      step(s, 1'b1);
      for (int j = 1; j < every; j++) step(s, 1'b0);
      k++;
      n += every;
    end
    if (n_pushed < target) check("window_budget", 64'(n_pushed), 64'(target));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2 * LAT) begin
      step(8'd0, 1'b0);
      n++;
    end
    step(8'd0, 1'b0);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    int seen0;
    logic [ACC-1:0] acc;
    vecs[0] = '{period: 64,  every: 1, windows: 2, exp_q: 131072};
    vecs[1] = '{period: 100, every: 1, windows: 2, exp_q: 83886};
    vecs[2] = '{period: 64,  every: 2, windows: 2, exp_q: 131072};
    samp = '0;
    samp_valid = 1'b0;
    cur_q = 0;
    cur_tol = 0;
    do_reset();

    check("reset_fcontrol_est", 64'(fcontrol_est), 64'd0);
    check("reset_est_valid",    64'(est_valid),    64'd0);
    check("reset_locked",       64'(locked),       64'd0);
    check("reset_busy",         64'(busy),         64'd0);

    // Noise inside the hysteresis band never produces an edge
    for (int i = 0; i < 300; i++) step(8'($urandom_range(0, 10)) - 8'd5, 1'b1);
    check("noise_no_est",    64'(n_seen), 64'd0);
    check("noise_busy",      64'(busy),   64'd0);
    check("noise_locked",    64'(locked), 64'd0);
    check("noise_fcontrol",  64'(fcontrol_est), 64'd0);

    foreach (vecs[i]) begin
      do_reset();
      run_sine(vecs[i].period, vecs[i].every, vecs[i].windows, vecs[i].exp_q, 0);
      drain();
      check("vec_locked",   64'(locked),       64'd1);
      check("vec_fcontrol", 64'(fcontrol_est), 64'(vecs[i].exp_q));
    end

    // Closed loop from a DDFS accumulator with fcontrol = 0x010000
    do_reset();
    cur_q = 65536;
    cur_tol = 1;
    acc = '0;
    begin
      int target, n;
      target = n_pushed + 1;
      n = 0;
      while (n_pushed < target && n < 6000) begin
        step(sine_s(real'(acc) / real'(1 << ACC)), 1'b1);
        acc = acc + ACC'(24'h010000);
        n++;
      end
      if (n_pushed < target) check("ddfs_budget", 64'(n_pushed), 64'(target));
    end
    drain();
    check("ddfs_locked", 64'(locked), 64'd1);

    // Loss of signal: constant -50 after lock times the window out
    do_reset();
    run_sine(64, 1, 1, 131072, 0);
    drain();
    check("pre_timeout_locked", 64'(locked), 64'd1);
    for (int i = 0; i < MAXC + 100 && !m_timed_out; i++) begin
      if (m_count && m_cnt == MAXC) check("locked_before_timeout", 64'(locked), 64'd1);
      step(8'hCE, 1'b1);
    end
    check("timeout_reached", 64'(m_timed_out), 64'd1);
    step(8'hCE, 1'b1);
    check("timeout_locked", 64'(locked), 64'd0);
    check("timeout_fcontrol_holds", 64'(fcontrol_est), 64'd131072);

    // Reset while the divider is running discards the result
    do_reset();
    run_sine(64, 1, 1, 131072, 0);
    check("busy_after_close", 64'(busy), 64'd1);
    repeat (10) step(8'd0, 1'b0);
    check("busy_mid_division", 64'(busy), 64'd1);
    seen0 = n_seen;
    rst = 1'b1;
    sb.delete();
    model_reset();
    #1;
    check("rst_async_busy",     64'(busy),         64'd0);
    check("rst_async_fcontrol", 64'(fcontrol_est), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) step(8'd0, 1'b0);
    check("rst_no_spurious_est", 64'(n_seen - seen0), 64'd0);
    check("rst_locked",          64'(locked),         64'd0);
    check("rst_fcontrol",        64'(fcontrol_est),   64'd0);
    run_sine(64, 1, 1, 131072, 0);
    drain();
    check("relock_locked",   64'(locked),       64'd1);
    check("relock_fcontrol", 64'(fcontrol_est), 64'd131072);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
